ram_dual_port_data: RTL
=======================

Name: ram_dual_port_data

Overview:
- Parametrised synchronous data RAM with one write port and one read port, both on a single clock.
- Adds byte-lane write enables, configurable read latency with a valid strobe, and out-of-range address protection.
- Includes a post-reset zero-initialisation sweep, so contents are defined before first use.
- Serves as the data memory behind the load/store path; the datapath reads oDataMemOut qualified by oReadValid.

Parameters:
DATA_WIDTH, 16, data word width in bits; must be a multiple of 8
ADDR_WIDTH, 10, address width in bits
MEM_SIZE, 1024, number of words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from read request to oReadValid; legal values 1 or 2

Ports:
iClock  input  1  clock, all logic on rising edge
iReset_n  input  1  asynchronous active-low reset
iMemEnable  input  1  global port enable; when low, no read or write is accepted
iWriteDataEnable  input  1  write request
iWriteByteEnable  input  DATA_WIDTH/8  per-byte write mask; bit k covers bits [8k+7:8k]
iWriteDataAddress  input  ADDR_WIDTH  write address
iDataMemIn  input  DATA_WIDTH  write data
iReadDataEnable  input  1  read request
iReadDataAddress  input  ADDR_WIDTH  read address
oDataMemOut  output  DATA_WIDTH  read data, valid when oReadValid=1
oReadValid  output  1  one-cycle strobe marking oDataMemOut valid
oInitBusy  output  1  high while the zero-initialisation sweep runs
oAddrError  output  1  one-cycle strobe on any accepted request with address >= MEM_SIZE

Behaviour:
- Reset (iReset_n low, asynchronous):
  - oDataMemOut=0, oReadValid=0, oAddrError=0, oInitBusy=1.
  - Read pipeline cleared; init counter=0; FSM enters INIT.
- FSM with two states, INIT and READY:
  - INIT: each cycle writes 0 to word[counter], then counter+1.
  - INIT -> READY: in the cycle that clears word MEM_SIZE-1. oInitBusy goes low the following cycle, so a full sweep is MEM_SIZE cycles after reset release.
  - In INIT, all user requests are ignored: no write, no oReadValid, no oAddrError.
  - Reset asserted mid-sweep restarts the sweep at 0.
- Request acceptance (READY only):
  - A write is accepted when iMemEnable & iWriteDataEnable.
  - A read is accepted when iMemEnable & iReadDataEnable.
  - A read and a write may be accepted in the same cycle.
- Write:
  - Only bytes with iWriteByteEnable[k]=1 are updated, at the clock edge.
  - All-zero mask: no change, but the request still counts as accepted.
- Read:
  - A read accepted at edge N gives oDataMemOut and oReadValid=1 at edge N+READ_LATENCY.
  - Back-to-back reads give one result per cycle, fully pipelined.
  - oDataMemOut holds its last value while oReadValid=0.
- Same-address read and write in the same cycle: read-first, i.e. the read returns the pre-write contents.
- Out of range (address >= MEM_SIZE):
  - Write is dropped.
  - Read completes on schedule with data 0 and oReadValid=1.
  - oAddrError pulses 1 cycle after acceptance, once per offending port; it is an OR of both ports if both are out of range.
- iMemEnable low: pipeline stages already in flight still complete.

Optional Feature:
- Macro: RAM_WRITE_FIRST_BYPASS_EN.
- Defined: on a same-cycle same-address read/write, the read returns the byte-merged new data. Enabled bytes come from iDataMemIn; other bytes keep old contents.
- Undefined: read-first behaviour as specified above.
- Latency and all other behaviour are identical in both builds.

Test Plan:
- Release reset, MEM_SIZE=1024 -> oInitBusy high for exactly 1024 cycles; requests issued during this window produce no oReadValid; then reads of addresses 0, 511 and 1023 return 0x0000.
- Write 0xABCD to addr 5 with mask 2'b11, then write 0x1234 with mask 2'b01, then read addr 5 -> 0xAB34 at edge N+1 with a 1-cycle oReadValid.
- READ_LATENCY=2, reads of addrs 1,2,3 on consecutive cycles (preloaded 0x0011, 0x0022, 0x0033) -> values appear in order at N+2, N+3, N+4 with oReadValid high for 3 cycles.
- Same cycle: write 0x5555 and read at addr 7 (old value 0x00AA) -> 0x00AA without the macro, 0x5555 with RAM_WRITE_FIRST_BYPASS_EN.
- MEM_SIZE=1000: write to addr 1010, then read addr 1010 -> write dropped, read returns 0x0000, oAddrError pulses once per request; a read of addr 999 is unaffected.
- Pull iReset_n low at cycle 300 of the sweep -> outputs clear immediately; after release, oInitBusy stays high for a full 1024 cycles.

Source files
------------

// File: rtl/ram_dual_port_data.sv
// rtl/ram_dual_port_data.sv - single-clock data RAM: byte-lane writes, pipelined reads, zero-init sweep
// Optional build macro: RAM_WRITE_FIRST_BYPASS_EN (same-address read returns merged new write data)
module ram_dual_port_data #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int MEM_SIZE     = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                    iClock,
  input  logic                    iReset_n,
  input  logic                    iMemEnable,
  input  logic                    iWriteDataEnable,
  input  logic [DATA_WIDTH/8-1:0] iWriteByteEnable,
  input  logic [ADDR_WIDTH-1:0]   iWriteDataAddress,
  input  logic [DATA_WIDTH-1:0]   iDataMemIn,
  input  logic                    iReadDataEnable,
  input  logic [ADDR_WIDTH-1:0]   iReadDataAddress,
  output logic [DATA_WIDTH-1:0]   oDataMemOut,
  output logic                    oReadValid,
  output logic                    oInitBusy,
  output logic                    oAddrError
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  // One extra bit so MEM_SIZE == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Control state
  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   init_cnt_q;
  logic                    init_busy_q;

  // Storage (no reset; contents are defined by the init sweep)
  logic [DATA_WIDTH-1:0]   mem_q [0:MEM_SIZE-1];

  // Request decode
  logic                    rd_acc;
  logic                    wr_acc;
  logic                    rd_oor;
  logic                    wr_oor;
  logic                    wr_hit;

  // Memory write port selection
  logic                    mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_waddr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_d;
  logic [NUM_BYTES-1:0]    mem_be_d;

  // Read path
  logic [DATA_WIDTH-1:0]   rd_word_d;
  logic                    pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_data;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    addr_err_d;
  logic                    addr_err_q;

  // Requests only count once the sweep has finished.
  assign rd_acc = (state_q == ST_READY) & iMemEnable & iReadDataEnable;
  assign wr_acc = (state_q == ST_READY) & iMemEnable & iWriteDataEnable;
  assign rd_oor = ({1'b0, iReadDataAddress}  >= MEM_LIMIT);
  assign wr_oor = ({1'b0, iWriteDataAddress} >= MEM_LIMIT);
  assign wr_hit = wr_acc & ~wr_oor;

  assign addr_err_d = (rd_acc & rd_oor) | (wr_acc & wr_oor);

  // Init/ready FSM with registered busy flag; the sweep walks every word once.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_busy_q <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ADDR) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        ST_READY: begin
          init_busy_q <= 1'b0;
        end
        default: begin
          state_q     <= ST_INIT;
          init_cnt_q  <= '0;
          init_busy_q <= 1'b1;
        end
      endcase
    end
  end

  // Write port mux: the sweep owns the port during INIT, the user afterwards.
  always_comb begin
    mem_we_d    = 1'b0;
    mem_waddr_d = iWriteDataAddress;
    mem_wdata_d = iDataMemIn;
    mem_be_d    = iWriteByteEnable;
    if (state_q == ST_INIT) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = init_cnt_q;
      mem_wdata_d = '0;
      mem_be_d    = '1;
    end else if (wr_hit) begin
      mem_we_d    = 1'b1;
    end
  end

  // Byte-lane write into the array.
  always_ff @(posedge iClock) begin
    if (mem_we_d) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (mem_be_d[k]) begin
          mem_q[mem_waddr_d][8*k +: 8] <= mem_wdata_d[8*k +: 8];
        end
      end
    end
  end

  // Read word selection: out-of-range reads return zero; same-address
  // collisions are read-first unless the bypass build merges the new bytes in.
  always_comb begin
    rd_word_d = '0;
    if (!rd_oor) begin
      rd_word_d = mem_q[iReadDataAddress];
    end
`ifdef RAM_WRITE_FIRST_BYPASS_EN
    if (!rd_oor && wr_hit && (iWriteDataAddress == iReadDataAddress)) begin
      for (int k = 0; k < NUM_BYTES; k++) begin
        if (iWriteByteEnable[k]) begin
          rd_word_d[8*k +: 8] = iDataMemIn[8*k +: 8];
        end
      end
    end
`else
    rd_word_d = rd_word_d;
`endif
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s1_valid_q;
      logic [DATA_WIDTH-1:0] s1_data_q;

      // Extra pipeline stage between array read and output register.
      always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
          s1_valid_q <= 1'b0;
          s1_data_q  <= '0;
        end else begin
          s1_valid_q <= rd_acc;
          if (rd_acc) begin
            s1_data_q <= rd_word_d;
          end
        end
      end

      assign pipe_valid = s1_valid_q;
      assign pipe_data  = s1_data_q;
    end else begin : g_lat1
      assign pipe_valid = rd_acc;
      assign pipe_data  = rd_word_d;
    end
  endgenerate

  // Output register: data only moves when a result is presented, so it
  // holds between valid strobes; the error strobe is a single-cycle pulse.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_valid_q <= pipe_valid;
      addr_err_q <= addr_err_d;
      if (pipe_valid) begin
        rd_data_q <= pipe_data;
      end
    end
  end

  assign oDataMemOut = rd_data_q;
  assign oReadValid  = rd_valid_q;
  assign oInitBusy   = init_busy_q;
  assign oAddrError  = addr_err_q;

endmodule
